bus_bridge: RTL and testbench

BUS_BRIDGE -- requirements
Module: bus_bridge

---
 rtl/bus_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_bus_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge.sv
// bus_bridge: connects the CPU data port to data RAM and to a small device bus.
// It also holds the board I/O registers: debounced switches, sticky button flags
// and a free-running timer.
//
// Ports
//   clk, rst_n         single clock; asynchronous active-low reset
//   cpu_addr/we/wdata  CPU data access (cpu_we is a one-cycle store strobe)
//   cpu_rdata          combinational load data (RAM or I/O register)
//   dram_we            data-RAM write enable, combinational, RAM region only
//   dram_rdata         data-RAM read data
//   dv_wr_e            one-cycle device-bus write strobe, one per I/O store
//   dv_addr            device-bus offset, held between strobes
//   data_fromcpu       device-bus write data, held between strobes
//   sw[23:0]           raw asynchronous switches
//   btn[4:0]           raw asynchronous active-high buttons
//
// Address map: cpu_addr[31:12] == 20'hFFFFF selects I/O, and cpu_addr[11:0] is
// the offset inside that region. Every other address goes to RAM.

// bus_bridge_debounce: a 2-flop synchronizer followed by a whole-vector
// debouncer. The output loads the candidate once the synchronized input has
// matched that candidate long enough for the counter to reach DB_CYC-1.
// db_next is the value db will take at the next edge, so the caller can
// detect edges in the same cycle.
module bus_bridge_debounce #(
  parameter int unsigned W      = 1,
  parameter logic [19:0] DB_CYC = 20'd1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db,
  output logic [W-1:0] db_next
);

  localparam logic [19:0] DB_LAST = DB_CYC - 20'd1;

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] cand;
  logic [W-1:0] cand_next;
  logic [19:0]  cnt;
  logic [19:0]  cnt_next;

  // Two-stage synchronizer. Nothing downstream sees the raw input directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Any change restarts the stability count on the new candidate.
  // A stable input counts up and saturates at DB_LAST.
  // db loads on the cycle the count arrives at DB_LAST.
  // When DB_LAST is 0, the count is already there when the candidate changes,
  // so db follows at that same edge.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    db_next   = db;
    if (sync != cand) begin
      cand_next = sync;
      cnt_next  = '0;
      if (DB_LAST == 20'd0) db_next = sync;
    end else if (cnt != DB_LAST) begin
      cnt_next = cnt + 20'd1;
      if (cnt + 20'd1 == DB_LAST) db_next = cand;
    end else begin
      db_next = cand;
    end
  end

  // Debouncer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      db   <= '0;
    end else begin
      cand <= cand_next;
      cnt  <= cnt_next;
      db   <= db_next;
    end
  end

endmodule

module bus_bridge #(
  parameter logic [11:0] LEDADDR = 12'h060,
  parameter logic [11:0] SWADDR  = 12'h070,
  parameter logic [11:0] BTNADDR = 12'h078,
  parameter logic [11:0] TMRADDR = 12'h020,
  parameter logic [19:0] DB_CYC  = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        dram_we,
  input  logic [31:0] dram_rdata,
  output logic        dv_wr_e,
  output logic [11:0] dv_addr,
  output logic [31:0] data_fromcpu,
  input  logic [23:0] sw,
  input  logic [4:0]  btn
);

  logic        io_sel;
  logic        io_wr;
  logic [11:0] io_off;
  logic [23:0] sw_db;
  logic [23:0] sw_db_next;
  logic [4:0]  btn_db;
  logic [4:0]  btn_db_next;
  logic [4:0]  btn_rise;
  logic [4:0]  btn_clr;
  logic [4:0]  btn_flag;
  logic [31:0] timer;

  assign io_sel  = (cpu_addr[31:12] == 20'hFFFFF);
  assign io_off  = cpu_addr[11:0];
  assign io_wr   = cpu_we & io_sel;
  assign dram_we = cpu_we & ~io_sel;

  bus_bridge_debounce #(.W(24), .DB_CYC(DB_CYC)) u_sw_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (sw),
    .db      (sw_db),
    .db_next (sw_db_next)
  );

  bus_bridge_debounce #(.W(5), .DB_CYC(DB_CYC)) u_btn_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (btn),
    .db      (btn_db),
    .db_next (btn_db_next)
  );

  // Device-bus write port. Each I/O store makes a single-cycle strobe.
  // Address and data change only when a new store is captured.
  // Because the strobe is rebuilt from io_wr on every edge, back-to-back stores
  // give back-to-back pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_wr_e      <= 1'b0;
      dv_addr      <= '0;
      data_fromcpu <= '0;
    end else begin
      dv_wr_e <= io_wr;
      if (io_wr) begin
        dv_addr      <= io_off;
        data_fromcpu <= cpu_wdata;
      end
    end
  end

  // A flag sets on the same edge its debounced button rises.
  // Writing 1s to BTNADDR clears flags.
  // The rise is ORed in after the clear, so a press on the clearing edge is
  // not lost.
  assign btn_rise = btn_db_next & ~btn_db;
  assign btn_clr  = (io_wr && io_off == BTNADDR) ? cpu_wdata[4:0] : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_flag <= '0;
    else        btn_flag <= (btn_flag & ~btn_clr) | btn_rise;
  end

  // Free-running timer that wraps naturally. A store to TMRADDR loads the timer,
  // and the load takes priority over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          timer <= '0;
    else if (io_wr && io_off == TMRADDR) timer <= cpu_wdata;
    else                                 timer <= timer + 32'd1;
  end

  // Load mux. This is purely combinational on the current register values, so
  // a store in the same cycle still reads the old contents.
  // The LED register is write-only here and reads back as zero.
  always_comb begin
    cpu_rdata = 32'b0;
    if (!io_sel) begin
      cpu_rdata = dram_rdata;
    end else begin
      case (io_off)
        SWADDR:  cpu_rdata = {8'b0, sw_db};
        BTNADDR: cpu_rdata = {27'b0, btn_flag};
        TMRADDR: cpu_rdata = timer;
        LEDADDR: cpu_rdata = 32'b0;
        default: cpu_rdata = 32'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Testbench for bus_bridge.
// It runs directed scenarios first: reset, I/O and RAM stores, switch glitch
// rejection, button flags, timer wrap and reset mid-operation. Randomized
// traffic follows. A cycle-level reference model in the bench supplies the
// expected value for every output.
module tb_bus_bridge;

  localparam logic [11:0] SWA  = 12'h070;
  localparam logic [11:0] BTNA = 12'h078;
  localparam logic [11:0] TMRA = 12'h020;
  localparam logic [11:0] LEDA = 12'h060;
  localparam int          DB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        dram_we;
  logic [31:0] dram_rdata;
  logic        dv_wr_e;
  logic [11:0] dv_addr;
  logic [31:0] data_fromcpu;
  logic [23:0] sw;
  logic [4:0]  btn;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic        mDvWr;
  logic [11:0] mDvAddr;
  logic [31:0] mDvData;
  logic [31:0] mTimer;
  logic [4:0]  mFlag;
  logic [23:0] mSwDb, swS1, swS2, swLast;
  logic [4:0]  mBtnDb, btnS1, btnS2, btnLast;
  int          swRun, btnRun;

  always #5 clk = ~clk;

  bus_bridge #(.DB_CYC(20'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .dram_we      (dram_we),
    .dram_rdata   (dram_rdata),
    .dv_wr_e      (dv_wr_e),
    .dv_addr      (dv_addr),
    .data_fromcpu (data_fromcpu),
    .sw           (sw),
    .btn          (btn)
  );

  function automatic logic isIo(input logic [31:0] a);
    return a[31:12] == 20'hFFFFF;
  endfunction

  // Expected load data. It is computed from the model state as it stood before
  // the coming edge.
  function automatic logic [31:0] expRdata();
    if (!isIo(cpu_addr)) return dram_rdata;
    case (cpu_addr[11:0])
      SWA:     return {8'b0, mSwDb};
      BTNA:    return {27'b0, mFlag};
      TMRA:    return mTimer;
      default: return 32'b0;
    endcase
  endfunction

  task automatic modelReset();
    mDvWr = 0; mDvAddr = 0; mDvData = 0; mTimer = 0; mFlag = 0;
    mSwDb = 0; swS1 = 0; swS2 = 0; swLast = 0; swRun = 1;
    mBtnDb = 0; btnS1 = 0; btnS2 = 0; btnLast = 0; btnRun = 1;
  endtask

  // Advance the model by one rising edge, using the inputs present before that
  // edge. The debounced value follows the synchronized input once that input
  // has been seen DB consecutive times.
  task automatic modelEdge();
    logic       ioWr;
    logic [4:0] newBtn, clr;
    if (!rst_n) begin
      modelReset();
      return;
    end
    ioWr = cpu_we && isIo(cpu_addr);
    if (swS2 == swLast) swRun = (swRun < DB) ? swRun + 1 : DB;
    else begin swLast = swS2; swRun = 1; end
    if (swRun >= DB) mSwDb = swLast;
    if (btnS2 == btnLast) btnRun = (btnRun < DB) ? btnRun + 1 : DB;
    else begin btnLast = btnS2; btnRun = 1; end
    newBtn = (btnRun >= DB) ? btnLast : mBtnDb;
    clr = (ioWr && cpu_addr[11:0] == BTNA) ? cpu_wdata[4:0] : 5'd0;
    mFlag = (mFlag & ~clr) | (newBtn & ~mBtnDb);
    mBtnDb = newBtn;
    swS2 = swS1; swS1 = sw;
    btnS2 = btnS1; btnS1 = btn;
    mTimer = (ioWr && cpu_addr[11:0] == TMRA) ? cpu_wdata : mTimer + 32'd1;
    mDvWr = ioWr;
    if (ioWr) begin mDvAddr = cpu_addr[11:0]; mDvData = cpu_wdata; end
  endtask

  // One comparison: it counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic checkAll();
    checkOutput("dram_we", {31'b0, dram_we}, {31'b0, cpu_we & ~isIo(cpu_addr)});
    checkOutput("cpu_rdata", cpu_rdata, expRdata());
    checkOutput("dv_wr_e", {31'b0, dv_wr_e}, {31'b0, mDvWr});
    checkOutput("dv_addr", {20'b0, dv_addr}, {20'b0, mDvAddr});
    checkOutput("data_fromcpu", data_fromcpu, mDvData);
  endtask

  // Run one clock cycle. The caller sets the inputs just after the edge. This
  // task checks all outputs mid-cycle, steps the model and returns 1ns after
  // the next rising edge.
  task automatic applyStimulus();
    #2;
    checkAll();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; cpu_addr = 0; cpu_we = 0; cpu_wdata = 0; dram_rdata = 32'h1234_5678;
    sw = 0; btn = 0;
    modelReset();
    #1;
    checkOutput("reset_dv_wr_e", {31'b0, dv_wr_e}, 32'd0);
    checkOutput("reset_dv_addr", {20'b0, dv_addr}, 32'd0);
    checkOutput("reset_data", data_fromcpu, 32'd0);
    applyStimulus();
    applyStimulus();
    rst_n = 1;
    repeat (3) applyStimulus();

    // I/O store produces a single strobe carrying its address and data.
    cpu_addr = 32'hFFFFF060; cpu_wdata = 32'h00ABCDEF; cpu_we = 1;
    #1 checkOutput("io_store_dram_we", {31'b0, dram_we}, 32'd0);
    applyStimulus();
    checkOutput("io_store_strobe", {31'b0, dv_wr_e}, 32'd1);
    checkOutput("io_store_addr", {20'b0, dv_addr}, 32'h060);
    checkOutput("io_store_data", data_fromcpu, 32'h00ABCDEF);
    cpu_we = 0; cpu_addr = 0;
    applyStimulus();
    checkOutput("io_store_drop", {31'b0, dv_wr_e}, 32'd0);
    checkOutput("io_store_hold", data_fromcpu, 32'h00ABCDEF);

    // RAM store.
    cpu_addr = 32'h10; cpu_wdata = 32'h5; cpu_we = 1;
    #1 checkOutput("ram_store_we", {31'b0, dram_we}, 32'd1);
    applyStimulus();
    checkOutput("ram_store_no_strobe", {31'b0, dv_wr_e}, 32'd0);
    cpu_we = 0;

    // Switch glitch rejection. A 2-cycle pulse is ignored, then a stable value
    // lands 2+DB cycles after it is applied.
    cpu_addr = 32'hFFFFF070;
    sw = 24'h1; applyStimulus(); applyStimulus();
    sw = 24'h0; applyStimulus();
    sw = 24'h1;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus();
      checkOutput($sformatf("sw_db_k%0d", k), cpu_rdata, (k == 6) ? 32'h1 : 32'h0);
    end

    // Button press sets a sticky flag, and a write-1 clears it.
    cpu_addr = 32'hFFFFF078;
    btn = 5'b00100;
    repeat (8) applyStimulus();
    checkOutput("btn_flag_set", cpu_rdata, 32'h4);
    cpu_we = 1; cpu_wdata = 32'h4;
    applyStimulus();
    cpu_we = 0;
    #1 checkOutput("btn_flag_clr", cpu_rdata, 32'h0);
    btn = 5'b0;
    repeat (8) applyStimulus();

    // A rise on the clearing edge takes priority over the clear.
    btn = 5'b00010;
    repeat (5) applyStimulus();
    cpu_we = 1; cpu_wdata = 32'h2;
    applyStimulus();
    cpu_we = 0;
    #1 checkOutput("btn_rise_beats_clr", cpu_rdata, 32'h2);

    // Timer load and wrap.
    cpu_addr = 32'hFFFFF020; cpu_wdata = 32'hFFFFFFFE; cpu_we = 1;
    applyStimulus();
    cpu_we = 0;
    #1 checkOutput("tmr_load", cpu_rdata, 32'hFFFFFFFE);
    applyStimulus();
    #1 checkOutput("tmr_max", cpu_rdata, 32'hFFFFFFFF);
    applyStimulus();
    #1 checkOutput("tmr_wrap", cpu_rdata, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: cpu_addr = $urandom & 32'h7FFFFFFF;
        1: cpu_addr = {20'hFFFFF, SWA};
        2: cpu_addr = {20'hFFFFF, BTNA};
        3: cpu_addr = {20'hFFFFF, TMRA};
        4: cpu_addr = {20'hFFFFF, LEDA};
        default: cpu_addr = {20'hFFFFF, 12'($urandom)};
      endcase
      cpu_we     = ($urandom_range(0, 2) == 0);
      cpu_wdata  = $urandom;
      dram_rdata = $urandom;
      if ($urandom_range(0, 6) == 0) sw  = 24'($urandom);
      if ($urandom_range(0, 6) == 0) btn = 5'($urandom);
      applyStimulus();
    end

    // Reset asserted the cycle after an I/O store.
    cpu_addr = 32'hFFFFF100; cpu_wdata = 32'h77; cpu_we = 1;
    applyStimulus();
    cpu_we = 0;
    checkOutput("pre_reset_strobe", {31'b0, dv_wr_e}, 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("async_reset_strobe", {31'b0, dv_wr_e}, 32'd0);
    checkOutput("async_reset_addr", {20'b0, dv_addr}, 32'd0);
    checkOutput("async_reset_data", data_fromcpu, 32'd0);
    modelReset();
    cpu_addr = 32'hFFFFF020;
    #1 checkOutput("async_reset_timer", cpu_rdata, 32'd0);
    cpu_addr = 32'h40; cpu_we = 1;
    #1 checkOutput("reset_dram_we_comb", {31'b0, dram_we}, 32'd1);
    cpu_we = 0;
    applyStimulus();
    applyStimulus();
    rst_n = 1;
    repeat (4) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
